mem_wb_stage: RTL

Memory-stage controller and MEM/WB pipeline register. It consumes the EX/MEM register outputs (control, ALU result, store data, destination register, flags) and performs the data-memory access through a valid/ready-style multi-cycle memory port. While an access is outstanding it stalls the upstream pipeline, then registers the results into MEM/WB for the write-back stage. It sits between the EX/MEM register and the write-back mux/register file.

---
 rtl/mem_wb_stage_pkg.sv | 19 +
 rtl/Bit16Reg.sv | 24 ++
 rtl/Bit3Reg.sv | 24 ++
 rtl/Bit4Reg.sv | 24 ++
 rtl/mem_wb_stage.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the memory stage: write-back control bit positions
// and the access FSM encoding.
package mem_wb_stage_pkg;

    localparam int WB_REGWRITE = 3;
    localparam int WB_MEMTOREG = 2;
    localparam int WB_PCTOREG  = 1;
    localparam int WB_HALT     = 0;

    // Every defined write-back control bit; anything else is forced low.
    localparam logic [3:0] WB_FIELDS = (4'b1 << WB_REGWRITE) | (4'b1 << WB_MEMTOREG) |
                                       (4'b1 << WB_PCTOREG)  | (4'b1 << WB_HALT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/Bit16Reg.sv
// 16-bit pipeline register cell with synchronous reset and write enable.
module Bit16Reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_en,
    input  logic [15:0] reg_in,
    output logic [15:0] reg_out
);

    logic [15:0] reg_q;
    logic [15:0] reg_d;

    always_comb begin
        reg_d = write_en ? reg_in : reg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) reg_q <= '0;
        else     reg_q <= reg_d;
    end

    assign reg_out = reg_q;

endmodule

// File: rtl/Bit3Reg.sv
// 3-bit pipeline register cell with synchronous reset and write enable.
module Bit3Reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       write_en,
    input  logic [2:0] reg_in,
    output logic [2:0] reg_out
);

    logic [2:0] reg_q;
    logic [2:0] reg_d;

    always_comb begin
        reg_d = write_en ? reg_in : reg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) reg_q <= '0;
        else     reg_q <= reg_d;
    end

    assign reg_out = reg_q;

endmodule

// File: rtl/Bit4Reg.sv
// 4-bit pipeline register cell with synchronous reset and write enable.
module Bit4Reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       write_en,
    input  logic [3:0] reg_in,
    output logic [3:0] reg_out
);

    logic [3:0] reg_q;
    logic [3:0] reg_d;

    always_comb begin
        reg_d = write_en ? reg_in : reg_q;
    end

    always_ff @(posedge clk) begin
        if (rst) reg_q <= '0;
        else     reg_q <= reg_d;
    end

    assign reg_out = reg_q;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-stage controller: issues data-memory accesses, stalls upstream while
// one is outstanding, and registers results into the MEM/WB pipeline register.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MemWrite,
    input  logic                   MemRead,
    input  logic [3:0]             WB_in,
    input  logic [15:0]            alu_in,
    input  logic [15:0]            rt_in,
    input  logic [3:0]             DstReg_in,
    input  logic [2:0]             flagsIn,
    output logic                   mem_en,
    output logic                   mem_wr,
    output logic [15:0]            mem_addr,
    output logic [15:0]            mem_wdata,
    input  logic [15:0]            mem_rdata,
    input  logic                   mem_data_valid,
    output logic                   stall_mem,
    output logic [3:0]             WB_out,
    output logic [15:0]            alu_out,
    output logic [15:0]            mem_data_out,
    output logic [3:0]             DstReg_out,
    output logic [2:0]             flagsOut,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic        req;
    logic        is_load;
    logic [3:0]  wb_d;
    logic [15:0] alu_d;
    logic [15:0] mem_data_d;
    logic [3:0]  dst_d;
    logic [2:0]  flags_d;

    // A simultaneous read and write request is treated as a write.
    assign req       = MemRead | MemWrite;
    assign is_load   = MemRead & ~MemWrite;
    assign mem_addr  = alu_in;
    assign mem_wdata = rt_in;

    // NOTE: every signal written in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        stall_mem = 1'b0;
        state_d   = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    mem_en    = 1'b1;
                    mem_wr    = MemWrite;
                    stall_mem = !mem_data_valid;
                    if (!mem_data_valid) state_d = BUSY;
                end
            end
            BUSY: begin
                stall_mem = !mem_data_valid;
                if (mem_data_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Any unstalled cycle with a request is the completion cycle, so the load
    // data on mem_rdata is valid whenever it is captured here.
    always_comb begin
        wb_d       = '0;
        alu_d      = '0;
        mem_data_d = '0;
        dst_d      = '0;
        flags_d    = '0;
        if (!stall_mem) begin
            wb_d       = WB_in & WB_FIELDS;
            alu_d      = alu_in;
            mem_data_d = is_load ? mem_rdata : '0;
            dst_d      = DstReg_in;
            flags_d    = flagsIn;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_mem && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

    Bit4Reg u_wb_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (1'b1),
        .reg_in   (wb_d),
        .reg_out  (WB_out)
    );

    Bit16Reg u_alu_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (1'b1),
        .reg_in   (alu_d),
        .reg_out  (alu_out)
    );

    Bit16Reg u_mem_data_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (1'b1),
        .reg_in   (mem_data_d),
        .reg_out  (mem_data_out)
    );

    Bit4Reg u_dst_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (1'b1),
        .reg_in   (dst_d),
        .reg_out  (DstReg_out)
    );

    Bit3Reg u_flags_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (1'b1),
        .reg_in   (flags_d),
        .reg_out  (flagsOut)
    );

endmodule
